sym_game_ctrl: RTL and testbench
================================

Name: sym_game_ctrl

Overview:
Round sequencer for the symbol-counting game. It gates the symbol generator through genSym and sets its speed through symGenMax. It counts the special symbols the generator emits and the player's button presses, then scores each round. Winning a round raises the level, which speeds up generation; losing a round ends the game. The block sits between the debounced button logic and the symbol generator, and drives the display and status logic.

Parameters:
COUNTDOWN_TICKS, 100_000_000, clocks spent in COUNTDOWN before each round (1 s at 100 MHz)
ROUND_TICKS, 500_000_000, clocks spent in PLAY per round
RESULT_TICKS, 200_000_000, clocks spent in RESULT showing the outcome
BASE_PERIOD, 100_000_000, symGenMax value at level 0
PERIOD_STEP, 10_000_000, decrease of symGenMax per level
MIN_PERIOD, 10_000_000, floor for symGenMax
MAX_LEVEL, 9, level saturation value

Ports:
Clk100M  in  1  system clock, 100 MHz
Reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse from the debounced start button
press  in  1  one-cycle pulse from the debounced player button
generated  in  1  symbol-generated strobe from the generator
special  in  1  target-symbol strobe from the generator
genSym  out  1  enables generation; high only in PLAY
symGenMax  out  32  generator period in clocks
level  out  4  current level, 0..MAX_LEVEL
targetCount  out  8  special strobes seen this round
pressCount  out  8  presses seen this round
roundWin  out  1  high in RESULT when pressCount == targetCount
gameOver  out  1  high in OVER
state  out  3  encoding: IDLE=0, COUNTDOWN=1, PLAY=2, RESULT=3, OVER=4

Behaviour:
- Single clock domain (Clk100M). Reset is synchronous and active-high and wins over every other input.
- Reset values: state=IDLE, genSym=0, symGenMax=BASE_PERIOD, level=0, targetCount=0, pressCount=0, roundWin=0, gameOver=0, internal tick timer=0.
- All outputs are registered. genSym, roundWin and gameOver are decoded from the next state, so each is valid in the same cycle the state register shows its state.
- IDLE: waits for start, then goes to COUNTDOWN. On entry to COUNTDOWN: timer=0, targetCount=0, pressCount=0.
- COUNTDOWN: timer increments each clock. When timer==COUNTDOWN_TICKS-1, go to PLAY with timer=0.
- PLAY: genSym=1.
  - special==1 increments targetCount, saturating at 255.
  - press==1 increments pressCount, saturating at 255.
  - When timer==ROUND_TICKS-1, go to RESULT with timer=0.
  - A press or special in that final PLAY cycle is still counted.
- Outside PLAY, press and special are ignored. generated is informational only and is not counted.
- RESULT: roundWin = (pressCount == targetCount), evaluated on the final counts. Counts are held for display.
  - After RESULT_TICKS clocks, a win increments level (saturating at MAX_LEVEL) and goes to COUNTDOWN. Counts clear on COUNTDOWN entry.
  - A loss goes to OVER.
- OVER: gameOver=1; level and counts are held. start returns to IDLE and sets level=0.
- start is ignored in COUNTDOWN, PLAY and RESULT.
- symGenMax = max(BASE_PERIOD - level*PERIOD_STEP, MIN_PERIOD).
  - Compute in 32 bits with no underflow: if level*PERIOD_STEP >= BASE_PERIOD - MIN_PERIOD, the result is MIN_PERIOD.
  - symGenMax updates only when level changes, never during PLAY. It is stable for the whole round.
- Timer is 32 bits unsigned, compared with ==, and never free-runs past its limit.
- Reset in any state, including mid-PLAY, drops genSym to 0 in the next cycle and clears all counts.

Test Plan:
- Use small parameters: COUNTDOWN_TICKS=4, ROUND_TICKS=20, RESULT_TICKS=3, BASE_PERIOD=10, PERIOD_STEP=3, MIN_PERIOD=2, MAX_LEVEL=9.
- Basic win: start; 3 special pulses and 3 presses in PLAY -> genSym high for exactly 20 clocks; roundWin=1; level 0->1; symGenMax 10->7; state returns to COUNTDOWN with counts cleared.
- Loss: 2 special, 3 presses -> roundWin=0 in RESULT; after 3 clocks state=OVER, gameOver=1, counts held at 2/3. Then start -> IDLE, level=0, symGenMax=10.
- Clamp and saturation: win 5 consecutive rounds -> symGenMax sequence 10,7,4,2,2,2. Force level to 9 and win -> level stays 9.
- Boundary events: press and special both asserted in the last PLAY cycle -> both counted. Press in COUNTDOWN and in RESULT -> not counted. 300 presses in one round -> pressCount=255.
- Ignored start: start pulsed in PLAY -> no state change, timer unaffected.
- Mid-round reset: Reset asserted at PLAY timer=10 -> next cycle state=IDLE, genSym=0, counts=0, symGenMax=10.

Source files
------------

// File: rtl/sym_game_ctrl.sv
// Round sequencer for the symbol-counting game: gates and paces the symbol
// generator, counts target symbols and player presses, and scores each round.
module sym_game_ctrl #(
   parameter int unsigned COUNTDOWN_TICKS = 100_000_000,
   parameter int unsigned ROUND_TICKS     = 500_000_000,
   parameter int unsigned RESULT_TICKS    = 200_000_000,
   parameter int unsigned BASE_PERIOD     = 100_000_000,
   parameter int unsigned PERIOD_STEP     = 10_000_000,
   parameter int unsigned MIN_PERIOD      = 10_000_000,
   parameter int unsigned MAX_LEVEL       = 9
) (
   input  logic        Clk100M,
   input  logic        Reset,
   input  logic        start,
   input  logic        press,
   input  logic        generated,
   input  logic        special,
   output logic        genSym,
   output logic [31:0] symGenMax,
   output logic [3:0]  level,
   output logic [7:0]  targetCount,
   output logic [7:0]  pressCount,
   output logic        roundWin,
   output logic        gameOver,
   output logic [2:0]  state
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] COUNTDOWN = 3'd1;
   localparam logic [2:0] PLAY      = 3'd2;
   localparam logic [2:0] RESULT    = 3'd3;
   localparam logic [2:0] OVER      = 3'd4;

   logic [31:0] timer, timer_nxt;
   logic [2:0]  state_nxt;
   logic [3:0]  level_nxt;
   logic [7:0]  target_nxt, press_nxt;

   // The generator strobe is informational only; this block never counts it.
   logic unused_generated;
   assign unused_generated = generated;

   // The subtraction is guarded so a high level clamps to the floor instead of wrapping.
   function automatic logic [31:0] period_for(input logic [3:0] lvl);
      logic [31:0] dec;
      dec = 32'(lvl) * PERIOD_STEP;
      if (dec >= BASE_PERIOD - MIN_PERIOD) return MIN_PERIOD;
      return BASE_PERIOD - dec;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default first, so no path through the case can infer a latch.
      state_nxt  = state;
      timer_nxt  = timer;
      level_nxt  = level;
      target_nxt = targetCount;
      press_nxt  = pressCount;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt  = COUNTDOWN;
               timer_nxt  = '0;
               target_nxt = '0;
               press_nxt  = '0;
            end
         end
         COUNTDOWN: begin
            if (timer == COUNTDOWN_TICKS - 1) begin
               state_nxt = PLAY;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 32'd1;
            end
         end
         PLAY: begin
            if (special && targetCount != 8'hFF) target_nxt = targetCount + 8'd1;
            if (press && pressCount != 8'hFF)    press_nxt  = pressCount + 8'd1;
            if (timer == ROUND_TICKS - 1) begin
               state_nxt = RESULT;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + 32'd1;
            end
         end
         RESULT: begin
            if (timer == RESULT_TICKS - 1) begin
               timer_nxt = '0;
               if (roundWin) begin
                  state_nxt  = COUNTDOWN;
                  target_nxt = '0;
                  press_nxt  = '0;
                  if (32'(level) < MAX_LEVEL) level_nxt = level + 4'd1;
               end else begin
                  state_nxt = OVER;
               end
            end else begin
               timer_nxt = timer + 32'd1;
            end
         end
         OVER: begin
            if (start) begin
               state_nxt = IDLE;
               level_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decode the next state so they line up with the state register.
   always_ff @(posedge Clk100M) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
      if (Reset) begin
         state       <= IDLE;
         timer       <= '0;
         level       <= '0;
         targetCount <= '0;
         pressCount  <= '0;
         genSym      <= 1'b0;
         roundWin    <= 1'b0;
         gameOver    <= 1'b0;
         symGenMax   <= BASE_PERIOD;
      end else begin
         state       <= state_nxt;
         timer       <= timer_nxt;
         level       <= level_nxt;
         targetCount <= target_nxt;
         pressCount  <= press_nxt;
         genSym      <= (state_nxt == PLAY);
         roundWin    <= (state_nxt == RESULT) && (press_nxt == target_nxt);
         gameOver    <= (state_nxt == OVER);
         symGenMax   <= period_for(level_nxt);
      end
   end

endmodule

// File: tb/tb_sym_game_ctrl.sv
// Directed bench for sym_game_ctrl using small timing parameters; a second
// instance with a long round exercises count saturation.
module tb_sym_game_ctrl;

   logic        Clk100M = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0, press = 1'b0, special = 1'b0, generated = 1'b0;
   logic        genSym, roundWin, gameOver;
   logic [31:0] symGenMax;
   logic [3:0]  level;
   logic [7:0]  targetCount, pressCount;
   logic [2:0]  state;

   logic        start_s = 1'b0, press_s = 1'b0, special_s = 1'b0;
   logic        genSym_s, roundWin_s, gameOver_s;
   logic [31:0] symGenMax_s;
   logic [3:0]  level_s;
   logic [7:0]  targetCount_s, pressCount_s;
   logic [2:0]  state_s;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   sym_game_ctrl #(
      .COUNTDOWN_TICKS(4), .ROUND_TICKS(20), .RESULT_TICKS(3),
      .BASE_PERIOD(10), .PERIOD_STEP(3), .MIN_PERIOD(2), .MAX_LEVEL(9)
   ) dut (
      .Clk100M(Clk100M), .Reset(Reset), .start(start), .press(press),
      .generated(generated), .special(special), .genSym(genSym),
      .symGenMax(symGenMax), .level(level), .targetCount(targetCount),
      .pressCount(pressCount), .roundWin(roundWin), .gameOver(gameOver),
      .state(state)
   );

   sym_game_ctrl #(
      .COUNTDOWN_TICKS(4), .ROUND_TICKS(310), .RESULT_TICKS(3),
      .BASE_PERIOD(10), .PERIOD_STEP(3), .MIN_PERIOD(2), .MAX_LEVEL(9)
   ) dut_sat (
      .Clk100M(Clk100M), .Reset(Reset), .start(start_s), .press(press_s),
      .generated(generated), .special(special_s), .genSym(genSym_s),
      .symGenMax(symGenMax_s), .level(level_s), .targetCount(targetCount_s),
      .pressCount(pressCount_s), .roundWin(roundWin_s), .gameOver(gameOver_s),
      .state(state_s)
   );

   always #5 Clk100M = ~Clk100M;

   always @(negedge Clk100M) generated = 1'($urandom_range(0, 1));

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
      $fatal(1);
   end

   task automatic tick();
      @(posedge Clk100M);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Entered with COUNTDOWN visible at timer 0; leaves with RESULT visible.
   task automatic do_round(input logic [19:0] spec_m, input logic [19:0] press_m,
                           input logic [19:0] start_m, input bit cd_press);
      int n;
      press = cd_press;
      tick();
      press = 1'b0;
      repeat (3) tick();
      chk("enter_play", 32'(state), 32'd2);
      n = 0;
      while (genSym === 1'b1 && n < 40) begin
         special = (n < 20) ? spec_m[n] : 1'b0;
         press   = (n < 20) ? press_m[n] : 1'b0;
         start   = (n < 20) ? start_m[n] : 1'b0;
         n++;
         tick();
      end
      special = 1'b0;
      press   = 1'b0;
      start   = 1'b0;
      chk("gensym_len", 32'(n), 32'd20);
      chk("enter_result", 32'(state), 32'd3);
   endtask

   task automatic win_tail(input int exp_lvl, input int exp_per);
      chk("win_flag", 32'(roundWin), 32'd1);
      repeat (3) tick();
      chk("next_countdown", 32'(state), 32'd1);
      chk("level_up", 32'(level), 32'(exp_lvl));
      chk("period", symGenMax, 32'(exp_per));
      chk("cleared_target", 32'(targetCount), 32'd0);
      chk("cleared_press", 32'(pressCount), 32'd0);
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_gensym", 32'(genSym), 32'd0);
      chk("rst_period", symGenMax, 32'd10);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_counts", {16'd0, targetCount, pressCount}, 32'd0);
      chk("rst_flags", {30'd0, roundWin, gameOver}, 32'd0);
      Reset = 1'b0;

      // Basic win: 3 specials, 3 presses; a countdown press is ignored.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_countdown", 32'(state), 32'd1);
      do_round(20'h00124, 20'h00248, 20'h0, 1'b1);
      chk("r1_target", 32'(targetCount), 32'd3);
      chk("r1_press", 32'(pressCount), 32'd3);
      chk("r1_win", 32'(roundWin), 32'd1);
      chk("r1_period_hold", symGenMax, 32'd10);
      press = 1'b1;
      tick();
      press = 1'b0;
      chk("result_press_ignored", 32'(pressCount), 32'd3);
      repeat (2) tick();
      chk("r1_countdown", 32'(state), 32'd1);
      chk("r1_level", 32'(level), 32'd1);
      chk("r1_period", symGenMax, 32'd7);
      chk("r1_cleared", {16'd0, targetCount, pressCount}, 32'd0);

      // Start pulsed mid-round must not disturb the 20-cycle round.
      do_round(20'h00124, 20'h00248, 20'h00020, 1'b0);
      win_tail(2, 4);

      // Press and special together in the final PLAY cycle both count.
      do_round(20'h80001, 20'h80002, 20'h0, 1'b0);
      chk("last_cycle_target", 32'(targetCount), 32'd2);
      chk("last_cycle_press", 32'(pressCount), 32'd2);
      win_tail(3, 2);
      do_round(20'h0, 20'h0, 20'h0, 1'b0);
      win_tail(4, 2);
      do_round(20'h0, 20'h0, 20'h0, 1'b0);
      win_tail(5, 2);
      for (int lvl = 6; lvl <= 9; lvl++) begin
         do_round(20'h0, 20'h0, 20'h0, 1'b0);
         win_tail(lvl, 2);
      end
      do_round(20'h0, 20'h0, 20'h0, 1'b0);
      win_tail(9, 2);

      // Loss: 2 specials vs 3 presses ends the game.
      do_round(20'h00003, 20'h00070, 20'h0, 1'b0);
      chk("loss_flag", 32'(roundWin), 32'd0);
      chk("loss_target", 32'(targetCount), 32'd2);
      chk("loss_press", 32'(pressCount), 32'd3);
      repeat (3) tick();
      chk("over_state", 32'(state), 32'd4);
      chk("over_flag", 32'(gameOver), 32'd1);
      repeat (2) tick();
      chk("over_hold_state", 32'(state), 32'd4);
      chk("over_hold_counts", {16'd0, targetCount, pressCount}, 32'h0203);
      chk("over_hold_level", 32'(level), 32'd9);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_idle", 32'(state), 32'd0);
      chk("restart_level", 32'(level), 32'd0);
      chk("restart_period", symGenMax, 32'd10);
      chk("restart_over_clr", 32'(gameOver), 32'd0);

      // Mid-round reset at PLAY timer 10, from level 1.
      start = 1'b1;
      tick();
      start = 1'b0;
      do_round(20'h0, 20'h0, 20'h0, 1'b0);
      win_tail(1, 7);
      repeat (4) tick();
      press   = 1'b1;
      special = 1'b1;
      repeat (10) tick();
      press   = 1'b0;
      special = 1'b0;
      chk("pre_reset_press", 32'(pressCount), 32'd10);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("midrst_state", 32'(state), 32'd0);
      chk("midrst_gensym", 32'(genSym), 32'd0);
      chk("midrst_counts", {16'd0, targetCount, pressCount}, 32'd0);
      chk("midrst_period", symGenMax, 32'd10);
      chk("midrst_level", 32'(level), 32'd0);

      // 300 presses and specials in one long round saturate at 255.
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      repeat (4) tick();
      chk("sat_play", 32'(state_s), 32'd2);
      press_s   = 1'b1;
      special_s = 1'b1;
      repeat (300) tick();
      press_s   = 1'b0;
      special_s = 1'b0;
      chk("sat_press", 32'(pressCount_s), 32'd255);
      chk("sat_target", 32'(targetCount_s), 32'd255);
      repeat (10) tick();
      chk("sat_result", 32'(state_s), 32'd3);
      chk("sat_win", 32'(roundWin_s), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
